// File: rtl/example_sched_pkg.sv
// rtl/example_sched_pkg.sv - opcodes and FSM state type shared by the scheduler and its bench
package example_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ARM,
        ST_SEL,
        ST_EXEC
    } state_t;

endpackage

// File: rtl/example_sched_rr_arbiter.sv
// rtl/example_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
// Ports:
//   req  in  N   request vector
//   ptr  in  PW  highest-priority index
//   win  out N   one-hot winner (zero when nothing requests)
//   any  out 1   some request is asserted
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any
);

    // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && req[j] && (j >= int'(ptr))) begin
                win[j] = 1'b1;
                any    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any && req[j]) begin
                win[j] = 1'b1;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/example_sched.sv
// rtl/example_sched.sv - round-robin scheduler driving a shared add/sub/clear accumulator
// Ports:
//   clk, rst      clock, async active-high reset
//   req/op/step   per-requester request, opcode (2b each), operand (W each)
//   gnt, done     one-hot grant and completion pulses
//   result        accumulator value (wire from dp_out)
//   dp_rst        synchronous reset to the datapath
//   dp_ctrl/step  datapath command
//   dp_out        datapath accumulator value
module example_sched
    import example_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [2*N-1:0] op,
    input  logic [W*N-1:0] step,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [W-1:0]   result,
    output logic           dp_rst,
    output logic           dp_ctrl,
    output logic [W-1:0]   dp_step,
    input  logic [W-1:0]   dp_out
);

    localparam int IW = $clog2(N);

    state_t         state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   step_q, step_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   done_q, done_d;
    logic           dp_ctrl_q, dp_ctrl_d;
    logic [W-1:0]   dp_step_q, dp_step_d;
    logic           dp_rst_q, dp_rst_d;

    logic [N-1:0]   win;
    logic           any;
    logic [IW-1:0]  win_idx;
    logic [1:0]     win_op;
    logic [W-1:0]   win_step;
    logic           last_cycle;
    logic           accept;

    // A requester granted this cycle may still hold req; it must not be sampled
    // again until the following edge.
    rr_arbiter #(.N(N), .PW(IW)) u_arb (
        .req (req & ~gnt_q),
        .ptr (ptr_q),
        .win (win),
        .any (any)
    );

    always_comb begin
        win_idx  = '0;
        win_op   = OP_ADD;
        win_step = '0;
        for (int j = 0; j < N; j++) begin
            if (win[j]) begin
                win_idx  = IW'(j);
                win_op   = op[2*j +: 2];
                win_step = step[W*j +: W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        step_d  = step_q;
        gnt_d   = '0;
        done_d  = '0;

        last_cycle = (state_q == ST_EXEC) || ((state_q == ST_SEL) && (op_q == OP_CLR));

        case (state_q)
            ST_INIT: state_d = ST_IDLE;
            ST_ARM:  state_d = ST_SEL;
            ST_SEL:  state_d = (op_q == OP_CLR) ? ST_IDLE : ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (last_cycle) begin
            done_d = N'(1) << idx_q;
        end

        // A READ winning in the last cycle of an op is deferred to the IDLE
        // cycle that follows, so its done never collides with the op's done.
        accept = any && ((state_q == ST_IDLE) || (last_cycle && (win_op != OP_READ)));

        if (accept) begin
            ptr_d  = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
            idx_d  = win_idx;
            op_d   = win_op;
            step_d = win_step;
            gnt_d  = win;
            if (win_op == OP_READ) begin
                done_d = win;
            end else begin
                state_d = ST_ARM;
            end
        end

        // Command outputs are registered, so they are derived from the next state.
        case (state_d)
            ST_ARM:  dp_ctrl_d = 1'b1;
            ST_SEL:  dp_ctrl_d = (op_d != OP_CLR);
            ST_EXEC: dp_ctrl_d = (op_d == OP_ADD);
            default: dp_ctrl_d = 1'b0;
        endcase
        dp_step_d = (state_d == ST_EXEC) ? step_d : '0;
        dp_rst_d  = (state_d == ST_INIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            idx_q     <= '0;
            op_q      <= OP_ADD;
            step_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            dp_ctrl_q <= 1'b0;
            dp_step_q <= '0;
            dp_rst_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            step_q    <= step_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            dp_ctrl_q <= dp_ctrl_d;
            dp_step_q <= dp_step_d;
            dp_rst_q  <= dp_rst_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign dp_ctrl = dp_ctrl_q;
    assign dp_step = dp_step_q;
    assign dp_rst  = dp_rst_q;
    assign result  = dp_out;

endmodule

// File: tb/tb_example_sched.sv
// tb/tb_example_sched.sv - directed self-checking bench for example_sched
module tb_example_sched;
    import example_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [15:0] step;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [3:0]  result;
    logic        dp_rst;
    logic        dp_ctrl;
    logic [3:0]  dp_step;
    logic [3:0]  dp_out;

    int n_checks = 0;
    int n_fail   = 0;

    example_sched #(.N(4), .W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op      (op),
        .step    (step),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .dp_rst  (dp_rst),
        .dp_ctrl (dp_ctrl),
        .dp_step (dp_step),
        .dp_out  (dp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator datapath stand-in: decodes the ctrl/step command protocol.
    logic [1:0] m_state;
    always_ff @(posedge clk) begin
        if (dp_rst) begin
            dp_out  <= 4'h0;
            m_state <= 2'd0;
        end else begin
            case (m_state)
                2'd0: if (dp_ctrl) m_state <= 2'd1;
                2'd1: begin
                    if (dp_ctrl) m_state <= 2'd2;
                    else begin
                        dp_out  <= 4'h0;
                        m_state <= 2'd0;
                    end
                end
                default: begin
                    dp_out  <= dp_ctrl ? dp_out + dp_step : dp_out - dp_step;
                    m_state <= 2'd0;
                end
            endcase
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [1:0] o, input logic [3:0] s);
        op[2*i +: 2] = o;
        step[4*i +: 4] = s;
    endtask

    task automatic test_reset;
        req = 4'b0;
        rst = 1'b1;
        next_cyc;
        next_cyc;
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL rst_gnt: got %b expected %b", gnt, 4'b0); end
        n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL rst_done: got %b expected %b", done, 4'b0); end
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b expected 0", dp_ctrl); end
        n_checks++; if (dp_step !== 4'h0) begin n_fail++; $display("FAIL rst_step: got %h expected 0", dp_step); end
        n_checks++; if (dp_rst !== 1'b1) begin n_fail++; $display("FAIL rst_dprst: got %b expected 1", dp_rst); end
        rst = 1'b0;
        #1;
        n_checks++; if (dp_rst !== 1'b1) begin n_fail++; $display("FAIL init_dprst: got %b expected 1", dp_rst); end
        next_cyc;
        n_checks++; if (dp_rst !== 1'b0) begin n_fail++; $display("FAIL idle_dprst: got %b expected 0", dp_rst); end
        n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL rst_dpout: got %h expected 0", dp_out); end
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL idle_ctrl: got %b expected 0", dp_ctrl); end
    endtask

    task automatic test_single_add;
        set_lane(0, OP_ADD, 4'd3);
        req = 4'b0001;
        next_cyc;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL add_gnt: got %b expected 0001", gnt); end
        n_checks++; if (dp_ctrl !== 1'b1) begin n_fail++; $display("FAIL add_ctrl1: got %b expected 1", dp_ctrl); end
        req = 4'b0;
        next_cyc;
        n_checks++; if (dp_ctrl !== 1'b1) begin n_fail++; $display("FAIL add_ctrl2: got %b expected 1", dp_ctrl); end
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL add_gnt_pulse: got %b expected 0000", gnt); end
        next_cyc;
        n_checks++; if (dp_ctrl !== 1'b1) begin n_fail++; $display("FAIL add_ctrl3: got %b expected 1", dp_ctrl); end
        n_checks++; if (dp_step !== 4'd3) begin n_fail++; $display("FAIL add_step: got %h expected 3", dp_step); end
        next_cyc;
        n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL add_done: got %b expected 0001", done); end
        n_checks++; if (result !== 4'd3) begin n_fail++; $display("FAIL add_result: got %h expected 3", result); end
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL add_ctrl_idle: got %b expected 0", dp_ctrl); end
    endtask

    task automatic test_sub_wrap;
        set_lane(2, OP_SUB, 4'd1);
        req = 4'b0100;
        next_cyc;
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL sub_gnt: got %b expected 0100", gnt); end
        n_checks++; if (dp_ctrl !== 1'b1) begin n_fail++; $display("FAIL sub_ctrl1: got %b expected 1", dp_ctrl); end
        req = 4'b0;
        next_cyc;
        n_checks++; if (dp_ctrl !== 1'b1) begin n_fail++; $display("FAIL sub_ctrl2: got %b expected 1", dp_ctrl); end
        next_cyc;
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL sub_ctrl3: got %b expected 0", dp_ctrl); end
        n_checks++; if (dp_step !== 4'd1) begin n_fail++; $display("FAIL sub_step: got %h expected 1", dp_step); end
        next_cyc;
        n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL sub_done: got %b expected 0100", done); end
        n_checks++; if (result !== 4'hF) begin n_fail++; $display("FAIL sub_result: got %h expected f", result); end
    endtask

    task automatic test_back_to_back;
        set_lane(1, OP_ADD, 4'd5);
        req = 4'b0010;
        next_cyc;
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt_add: got %b expected 0010", gnt); end
        set_lane(1, OP_CLR, 4'd0);
        next_cyc;
        next_cyc;
        n_checks++; if (dp_step !== 4'd5) begin n_fail++; $display("FAIL b2b_step: got %h expected 5", dp_step); end
        next_cyc;
        n_checks++; if (done !== 4'b0010) begin n_fail++; $display("FAIL b2b_done_add: got %b expected 0010", done); end
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL b2b_gnt_clr: got %b expected 0010", gnt); end
        n_checks++; if (result !== 4'd5) begin n_fail++; $display("FAIL b2b_result_add: got %h expected 5", result); end
        n_checks++; if (dp_ctrl !== 1'b1) begin n_fail++; $display("FAIL clr_ctrl1: got %b expected 1", dp_ctrl); end
        req = 4'b0;
        next_cyc;
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL clr_ctrl2: got %b expected 0", dp_ctrl); end
        n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL clr_early_done: got %b expected 0000", done); end
        next_cyc;
        n_checks++; if (done !== 4'b0010) begin n_fail++; $display("FAIL clr_done: got %b expected 0010", done); end
        n_checks++; if (result !== 4'd0) begin n_fail++; $display("FAIL clr_result: got %h expected 0", result); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt;
        logic [3:0] exp_done;
        logic [3:0] exp_res;
        for (int i = 0; i < 4; i++) set_lane(i, OP_ADD, 4'd1);
        req = 4'b1111;
        for (int c = 1; c <= 16; c++) begin
            next_cyc;
            exp_gnt  = (c <= 13 && c % 3 == 1) ? (4'b0001 << (((c - 1) / 3) % 4)) : 4'b0;
            exp_done = (c >= 4 && c % 3 == 1) ? (4'b0001 << (((c - 4) / 3) % 4)) : 4'b0;
            exp_res  = 4'((c - 4) / 3 + 1);
            n_checks++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); end
            n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL rr_done c%0d: got %b expected %b", c, done, exp_done); end
            if (exp_done != 4'b0) begin
                n_checks++; if (result !== exp_res) begin n_fail++; $display("FAIL rr_result c%0d: got %h expected %h", c, result, exp_res); end
            end
            if (c == 13) req = 4'b0;
        end
    endtask

    task automatic test_reset_mid_op;
        set_lane(2, OP_ADD, 4'd7);
        set_lane(0, OP_ADD, 4'd6);
        set_lane(3, OP_ADD, 4'd2);
        req = 4'b0100;
        next_cyc;
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_gnt: got %b expected 0100", gnt); end
        req = 4'b0;
        next_cyc;
        rst = 1'b1;
        #1;
        n_checks++; if (dp_rst !== 1'b1) begin n_fail++; $display("FAIL mid_dprst: got %b expected 1", dp_rst); end
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl: got %b expected 0", dp_ctrl); end
        next_cyc;
        n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL mid_done_rst: got %b expected 0000", done); end
        rst = 1'b0;
        req = 4'b1001;
        #1;
        n_checks++; if (dp_rst !== 1'b1) begin n_fail++; $display("FAIL mid_init_dprst: got %b expected 1", dp_rst); end
        next_cyc;
        n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL mid_done_idle: got %b expected 0000", done); end
        n_checks++; if (dp_rst !== 1'b0) begin n_fail++; $display("FAIL mid_dprst_low: got %b expected 0", dp_rst); end
        n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL mid_dpout: got %h expected 0", dp_out); end
        next_cyc;
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_next_gnt: got %b expected 0001", gnt); end
        req = 4'b0;
        next_cyc;
        next_cyc;
        next_cyc;
        n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL mid_next_done: got %b expected 0001", done); end
        n_checks++; if (result !== 4'd6) begin n_fail++; $display("FAIL mid_next_result: got %h expected 6", result); end
    endtask

    task automatic test_read;
        set_lane(1, OP_READ, 4'd0);
        set_lane(2, OP_READ, 4'd0);
        req = 4'b0110;
        next_cyc;
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL read1_gnt: got %b expected 0010", gnt); end
        n_checks++; if (done !== 4'b0010) begin n_fail++; $display("FAIL read1_done: got %b expected 0010", done); end
        n_checks++; if (result !== 4'd6) begin n_fail++; $display("FAIL read1_result: got %h expected 6", result); end
        n_checks++; if (dp_ctrl !== 1'b0) begin n_fail++; $display("FAIL read1_ctrl: got %b expected 0", dp_ctrl); end
        next_cyc;
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL read2_gnt: got %b expected 0100", gnt); end
        n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL read2_done: got %b expected 0100", done); end
        req = 4'b0;
        next_cyc;
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL read_quiet_gnt: got %b expected 0000", gnt); end
        n_checks++; if (done !== 4'b0) begin n_fail++; $display("FAIL read_quiet_done: got %b expected 0000", done); end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0;
        op   = 8'h0;
        step = 16'h0;
        test_reset;
        test_single_add;
        test_reset;
        test_sub_wrap;
        test_reset;
        test_back_to_back;
        test_reset;
        test_round_robin;
        test_reset_mid_op;
        test_read;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
